bus_rr_arbiter: RTL

Parametrised shared-bus generator and arbiter. It is the next generation of bs_gnrtr_n_rbtr and connects DRVRS device FIFOs.
- Each device presents its outgoing FIFO head (pndng/D_pop). The arbiter pops one packet at a time, in round-robin order, and pushes it to the destination device's incoming FIFO (push/D_push).
- New over the previous block: destination backpressure (full), broadcast to all-but-source, invalid-destination drop, stall timeout, and on-chip per-destination delivery and drop statistics. These statistics replace bench-side bandwidth counting.

---
 rtl/bus_pkg.sv | 52 +++++
 rtl/bus_rr_arbiter_rr_pick.sv | 31 +++
 rtl/bus_rr_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
//   state_t      : arbiter FSM states (IDLE, GRANT, DELIVER)
//   get_dest     : extracts the destination ID field from the top of a packet
//   target_mask  : decodes a destination into a per-device push mask, where an
//                  all-zero result marks the packet as undeliverable
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        DELIVER
    } state_t;

    localparam int MAX_DRVRS = 16;
    localparam int MAX_BITS  = 256;

    // The packet is handed in zero-extended to MAX_BITS so one function serves
    // every packet width; the ID field (at most 32 bits) sits at the top of
    // the real packet width.
    function automatic logic [31:0] get_dest(
        input logic [MAX_BITS-1:0] pkt,
        input int unsigned         bits,
        input int unsigned         idW
    );
        logic [31:0] mask;
        mask = (idW >= 32) ? 32'hFFFF_FFFF : ((32'd1 << idW) - 32'd1);
        return 32'(pkt >> (bits - idW)) & mask;
    endfunction

    // Broadcast reaches everyone but the sender. A unicast to a device that
    // does not exist, or back to the sender itself, yields an empty mask.
    function automatic logic [MAX_DRVRS-1:0] target_mask(
        input logic [31:0] dest,
        input logic [31:0] src,
        input logic [31:0] drvrs,
        input logic [31:0] broadcast
    );
        logic [MAX_DRVRS-1:0] m;
        m = '0;
        if (dest == broadcast) begin
            for (int i = 0; i < MAX_DRVRS; i++) begin
                if ((32'(i) < drvrs) && (32'(i) != src)) begin
                    m[i] = 1'b1;
                end
            end
        end else if ((dest < drvrs) && (dest != src)) begin
            m[dest[3:0]] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Combinational round-robin priority selector.
//   req     : one request bit per device
//   last    : index of the most recently granted device
//   gnt_idx : first requesting device found scanning from last+1 with wrap
//   any_req : at least one request bit is set
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any_req
);

    // Walk the devices starting one past the last winner, so the last winner
    // is considered only after everyone else; the first hit is the grant.
    always_comb begin
        gnt_idx = '0;
        any_req = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (int'(last) + k) % N;
            if (!any_req && req[idx]) begin
                gnt_idx = IDX_W'(idx);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Shared-bus round-robin arbiter between DRVRS device FIFOs.
//   clk, reset         : rising-edge clock, asynchronous active-low reset
//   pndng, D_pop, pop  : outgoing FIFO heads of each device and pop strobes
//   full, push, D_push : incoming FIFO full flags, push strobes and data
//   clr_stats          : synchronous clear of all statistics counters
//   busy               : arbiter is working on a packet
//   msg_cnt, drop_cnt  : saturating delivered-per-destination and drop counters
// One packet is moved per IDLE -> GRANT -> DELIVER pass. Delivery is
// all-or-nothing: every target must have room before any is pushed.
module bus_rr_arbiter
    import bus_pkg::*;
#(
    parameter int               BITS      = 32,
    parameter int               DRVRS     = 4,
    parameter int               ID_W      = 8,
    parameter logic [ID_W-1:0]  BROADCAST = 8'hFF,
    parameter int               CNT_W     = 16,
    parameter int               TIMEOUT   = 64
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DRVRS-1:0]                  pndng,
    input  logic [DRVRS-1:0][BITS-1:0]        D_pop,
    output logic [DRVRS-1:0]                  pop,
    input  logic [DRVRS-1:0]                  full,
    output logic [DRVRS-1:0]                  push,
    output logic [DRVRS-1:0][BITS-1:0]        D_push,
    input  logic                              clr_stats,
    output logic                              busy,
    output logic [DRVRS-1:0][CNT_W-1:0]       msg_cnt,
    output logic [CNT_W-1:0]                  drop_cnt
);

    localparam int IDX_W  = $clog2(DRVRS);
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t                       state_q;
    logic [IDX_W-1:0]             lastGrant_q;
    logic [IDX_W-1:0]             grant_q;
    logic [IDX_W-1:0]             src_q;
    logic [BITS-1:0]              pkt_q;
    logic [WAIT_W-1:0]            waitCnt_q;
    logic [DRVRS-1:0]             pop_q;
    logic [DRVRS-1:0]             push_q;
    logic [BITS-1:0]              dPush_q;
    logic                         busy_q;
    logic [DRVRS-1:0][CNT_W-1:0]  msgCnt_q;
    logic [CNT_W-1:0]             dropCnt_q;

    logic [IDX_W-1:0]             pickIdx;
    logic                         anyReq;
    logic [31:0]                  dest;
    logic [DRVRS-1:0]             targets;
    logic                         blocked;

    rr_pick #(
        .N     (DRVRS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req     (pndng),
        .last    (lastGrant_q),
        .gnt_idx (pickIdx),
        .any_req (anyReq)
    );

    // Decode the held packet into its push mask and see whether any of the
    // targets is currently unable to accept it.
    always_comb begin
        dest    = get_dest(MAX_BITS'(pkt_q), BITS, ID_W);
        targets = DRVRS'(target_mask(dest, 32'(src_q), 32'(DRVRS), 32'(BROADCAST)));
        blocked = |(targets & full);
    end

    // Arbiter FSM with all outputs registered. Pop and push strobes default
    // low every cycle so they last exactly one cycle. Statistics are updated
    // alongside the FSM and a clear request, handled last, overrides any
    // increment made in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            lastGrant_q <= IDX_W'(DRVRS - 1);
            grant_q     <= '0;
            src_q       <= '0;
            pkt_q       <= '0;
            waitCnt_q   <= '0;
            pop_q       <= '0;
            push_q      <= '0;
            dPush_q     <= '0;
            busy_q      <= 1'b0;
            msgCnt_q    <= '0;
            dropCnt_q   <= '0;
        end else begin
            pop_q   <= '0;
            push_q  <= '0;
            dPush_q <= '0;
            case (state_q)
                IDLE: begin
                    if (anyReq) begin
                        grant_q     <= pickIdx;
                        lastGrant_q <= pickIdx;
                        state_q     <= GRANT;
                        busy_q      <= 1'b1;
                    end
                end
                GRANT: begin
                    if (pndng[grant_q]) begin
                        pop_q[grant_q] <= 1'b1;
                        pkt_q          <= D_pop[grant_q];
                        src_q          <= grant_q;
                        state_q        <= DELIVER;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                DELIVER: begin
                    if (targets == '0) begin
                        if (dropCnt_q != '1) begin
                            dropCnt_q <= dropCnt_q + CNT_W'(1);
                        end
                        waitCnt_q <= '0;
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                    end else if (!blocked) begin
                        push_q  <= targets;
                        dPush_q <= pkt_q;
                        for (int i = 0; i < DRVRS; i++) begin
                            if (targets[i] && (msgCnt_q[i] != '1)) begin
                                msgCnt_q[i] <= msgCnt_q[i] + CNT_W'(1);
                            end
                        end
                        waitCnt_q <= '0;
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                    end else if ((TIMEOUT != 0) && (waitCnt_q == WAIT_W'(TIMEOUT - 1))) begin
                        if (dropCnt_q != '1) begin
                            dropCnt_q <= dropCnt_q + CNT_W'(1);
                        end
                        waitCnt_q <= '0;
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                    end else begin
                        waitCnt_q <= waitCnt_q + WAIT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            if (clr_stats) begin
                msgCnt_q  <= '0;
                dropCnt_q <= '0;
            end
        end
    end

    assign pop      = pop_q;
    assign push     = push_q;
    assign D_push   = {DRVRS{dPush_q}};
    assign busy     = busy_q;
    assign msg_cnt  = msgCnt_q;
    assign drop_cnt = dropCnt_q;

endmodule
